// File: rtl/ad7606x_par_rd_seq_if.sv
// ad7606x_par_rd_seq_if: AD7606x parallel-interface pins between the sequencer (master) and the ADC (slave).
interface ad7606x_par_rd_seq_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  rx_busy;
    logic [DATA_WIDTH-1:0] rx_db_i;
    logic [DATA_WIDTH-1:0] rx_db_o;
    logic                  rx_db_t;
    logic                  rx_wr_n;
    logic                  rx_cnvst_n;
    logic                  rx_cs_n;
    logic                  rx_rd_n;
    modport master (
        input  rx_busy, rx_db_i,
        output rx_db_o, rx_db_t, rx_wr_n, rx_cnvst_n, rx_cs_n, rx_rd_n
    );
    modport slave (
        output rx_busy, rx_db_i,
        input  rx_db_o, rx_db_t, rx_wr_n, rx_cnvst_n, rx_cs_n, rx_rd_n
    );
endinterface

// File: rtl/ad7606x_par_rd_seq.sv
// ad7606x_par_rd_seq: AD7606x conversion start, busy handshake and CS/RD burst readout sequencer.
module ad7606x_par_rd_seq #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CH_MAX   = 17,
    parameter int CNVST_CYC    = 2,
    parameter int RD_LO_CYC    = 3,
    parameter int RD_HI_CYC    = 2,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  start,
    input  logic [4:0]            num_ch,
    ad7606x_par_rd_seq_if.master  adc,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_data_valid,
    output logic                  rx_first_data,
    output logic [4:0]            rx_ch_count,
    output logic                  done,
    output logic                  busy_err,
    output logic                  seq_active
);
    localparam int CW = $clog2(CNVST_CYC + RD_LO_CYC + RD_HI_CYC);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CNVST, WAIT_BH, WAIT_BL, CS_SU, RD_LO, RD_HI, END_S} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cyc_q, cyc_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [4:0]            n_lat_q, n_lat_d;
    logic                  seen_q, seen_d;
    logic [1:0]            bsync_q;
    logic                  cnvst_n_q, cnvst_n_d;
    logic                  cs_n_q, cs_n_d;
    logic                  rd_n_q, rd_n_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  first_q, first_d;
    logic [4:0]            cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  busy_s;
    logic                  tmo_hit;

    assign busy_s  = bsync_q[1];
    assign tmo_hit = tmo_q == TW'(BUSY_TIMEOUT - 1);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            cyc_q     <= '0;
            tmo_q     <= '0;
            n_lat_q   <= '0;
            seen_q    <= 1'b0;
            bsync_q   <= '0;
            cnvst_n_q <= 1'b1;
            cs_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            data_q    <= '0;
            valid_q   <= 1'b0;
            first_q   <= 1'b0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            tmo_q     <= tmo_d;
            n_lat_q   <= n_lat_d;
            seen_q    <= seen_d;
            bsync_q   <= {bsync_q[0], adc.rx_busy};
            cnvst_n_q <= cnvst_n_d;
            cs_n_q    <= cs_n_d;
            rd_n_q    <= rd_n_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            first_q   <= first_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Every done (normal, empty burst or timeout) passes through END_S, so a start in the done cycle is dropped.
    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        tmo_d     = tmo_q;
        n_lat_d   = n_lat_q;
        seen_d    = seen_q;
        cnvst_n_d = cnvst_n_q;
        cs_n_d    = cs_n_q;
        rd_n_d    = rd_n_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        first_d   = 1'b0;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                n_lat_d   = (num_ch > 5'(NUM_CH_MAX)) ? 5'(NUM_CH_MAX) : num_ch;
                cnvst_n_d = 1'b0;
                cyc_d     = '0;
                seen_d    = 1'b0;
                state_d   = CNVST;
            end
            CNVST: begin
                seen_d = seen_q | busy_s;
                if (cyc_q == CW'(CNVST_CYC - 1)) begin
                    cnvst_n_d = 1'b1;
                    tmo_d     = '0;
                    state_d   = WAIT_BH;
                end else cyc_d = cyc_q + 1'b1;
            end
            WAIT_BH: begin
                seen_d = seen_q | busy_s;
                tmo_d  = tmo_q + 1'b1;
                if (tmo_hit) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = END_S;
                end else if (seen_q || busy_s) state_d = WAIT_BL;
            end
            WAIT_BL: begin
                tmo_d = tmo_q + 1'b1;
                if (tmo_hit) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = END_S;
                end else if (!busy_s) begin
                    done_d  = n_lat_q == '0;
                    cs_n_d  = n_lat_q == '0;
                    state_d = (n_lat_q == '0) ? END_S : CS_SU;
                end
            end
            CS_SU: begin
                rd_n_d  = 1'b0;
                cyc_d   = '0;
                state_d = RD_LO;
            end
            RD_LO: if (cyc_q == CW'(RD_LO_CYC - 1)) begin
                rd_n_d  = 1'b1;
                data_d  = adc.rx_db_i;
                cnt_d   = cnt_q + 1'b1;
                valid_d = 1'b1;
                first_d = cnt_q == '0;
                cyc_d   = '0;
                state_d = RD_HI;
            end else cyc_d = cyc_q + 1'b1;
            RD_HI: if (cyc_q == CW'(RD_HI_CYC - 1)) begin
                cyc_d   = '0;
                rd_n_d  = !(cnt_q < n_lat_q);
                cs_n_d  = !(cnt_q < n_lat_q);
                done_d  = !(cnt_q < n_lat_q);
                state_d = (cnt_q < n_lat_q) ? RD_LO : END_S;
            end else cyc_d = cyc_q + 1'b1;
            END_S: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign adc.rx_db_o    = '0;
    assign adc.rx_db_t    = 1'b1;
    assign adc.rx_wr_n    = 1'b1;
    assign adc.rx_cnvst_n = cnvst_n_q;
    assign adc.rx_cs_n    = cs_n_q;
    assign adc.rx_rd_n    = rd_n_q;
    assign rx_data        = data_q;
    assign rx_data_valid  = valid_q;
    assign rx_first_data  = first_q;
    assign rx_ch_count    = cnt_q;
    assign done           = done_q;
    assign busy_err       = err_q;
    assign seq_active     = state_q != IDLE;
endmodule

// File: tb/tb_ad7606x_par_rd_seq.sv
// tb_ad7606x_par_rd_seq: scoreboard bench with a behavioural AD7606x model driving busy and the data bus.
module tb_ad7606x_par_rd_seq;
    localparam int DW = 16;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          start = 1'b0;
    logic [4:0]    num_ch = '0;
    logic          busy_pulse = 1'b0;
    logic          busy_stuck = 1'b0;
    logic [DW-1:0] rx_data;
    logic          rx_data_valid;
    logic          rx_first_data;
    logic [4:0]    rx_ch_count;
    logic          done;
    logic          busy_err;
    logic          seq_active;

    ad7606x_par_rd_seq_if #(.DATA_WIDTH(DW)) adc ();

    assign adc.rx_busy = busy_pulse | busy_stuck;

    ad7606x_par_rd_seq dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .start         (start),
        .num_ch        (num_ch),
        .adc           (adc),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_first_data (rx_first_data),
        .rx_ch_count   (rx_ch_count),
        .done          (done),
        .busy_err      (busy_err),
        .seq_active    (seq_active)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [4:0]    idx;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_new;
    exp_t e_pop;
    int   n_chk = 0;
    int   n_err = 0;
    int   rd_falls, n_valid, n_done, n_errp, n_cnvst, cs_lo, rd_cs_viol;
    int   rd_idx = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ADC model: busy follows the conversion start asynchronously to the clock
    always @(negedge adc.rx_cnvst_n) begin
        #13 busy_pulse = 1'b1;
        #37 busy_pulse = 1'b0;
    end

    // ADC model: each RD falling edge puts the next word on the bus and records the expectation
    always @(negedge adc.rx_rd_n or posedge adc.rx_cs_n) begin
        if (adc.rx_cs_n) rd_idx = 0;
        else begin
            rd_idx++;
            e_new.d = DW'($urandom);
            e_new.idx = 5'(rd_idx);
            adc.rx_db_i = e_new.d;
            exp_q.push_back(e_new);
        end
    end

    logic prev_rd = 1'b1;
    logic prev_cv = 1'b1;
    int   lo_len = 0;
    int   hi_len = 0;
    bit   armed = 0;
    bit   gap = 0;

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            prev_rd = 1'b1;
            prev_cv = 1'b1;
            armed = 0;
            gap = 0;
        end else begin
            if (!adc.rx_rd_n && adc.rx_cs_n) rd_cs_viol++;
            if (!adc.rx_cs_n) cs_lo++;
            if (!adc.rx_cnvst_n && prev_cv) n_cnvst++;
            if (!adc.rx_rd_n) begin
                if (prev_rd) begin
                    rd_falls++;
                    if (gap) check("rd_hi_width", hi_len, 2);
                    armed = 1;
                    lo_len = 0;
                end
                lo_len++;
            end else begin
                if (!prev_rd) begin
                    if (armed) check("rd_lo_width", lo_len, 3);
                    armed = 0;
                    gap = 1;
                    hi_len = 0;
                end
                hi_len++;
            end
            if (adc.rx_cs_n) gap = 0;
            prev_rd = adc.rx_rd_n;
            prev_cv = adc.rx_cnvst_n;
            if (done) n_done++;
            if (busy_err) begin
                n_errp++;
                check("err_with_done", done, 1);
            end
            if (rx_data_valid) begin
                n_valid++;
                check("q_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e_pop = exp_q.pop_front();
                    check("data", rx_data, e_pop.d);
                    check("ch_count", rx_ch_count, e_pop.idx);
                    check("first", rx_first_data, 32'(e_pop.idx == 5'd1));
                end
            end
        end
    end

    task automatic clr();
        rd_falls = 0;
        n_valid = 0;
        n_done = 0;
        n_errp = 0;
        n_cnvst = 0;
        cs_lo = 0;
        rd_cs_viol = 0;
    endtask

    task automatic run(input int n, input int exp_n, input bit drop);
        bit got = 0;
        bit dropped = 0;
        clr();
        num_ch = 5'(n);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        num_ch = 5'(~n);
        check("cnvst_latency", adc.rx_cnvst_n, 0);
        check("active", seq_active, 1);
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge sys_clk);
            start = 1'b0;
            if (drop && !dropped && n_valid >= 8) begin
                start = 1'b1;
                dropped = 1;
            end
            if (done) begin
                got = 1;
                check("cnt_at_done", rx_ch_count, exp_n);
                check("cs_at_done", adc.rx_cs_n, 1);
                if (drop) start = 1'b1;
            end
        end
        check("done_seen", got, 1);
        @(negedge sys_clk);
        start = 1'b0;
        check("cnt_cleared", rx_ch_count, 0);
        check("idle_after", seq_active, 0);
        repeat (4) @(negedge sys_clk);
        check("rd_pulses", rd_falls, exp_n);
        check("valid_pulses", n_valid, exp_n);
        check("done_pulses", n_done, 1);
        check("err_pulses", n_errp, 0);
        check("conversions", n_cnvst, 1);
        check("rd_while_cs_hi", rd_cs_viol, 0);
        check("q_left", exp_q.size(), 0);
        check("cs_idle", adc.rx_cs_n, 1);
    endtask

    initial begin
        int cyc;
        bit got;
        repeat (3) @(negedge sys_clk);
        check("rst_cnvst_n", adc.rx_cnvst_n, 1);
        check("rst_cs_n", adc.rx_cs_n, 1);
        check("rst_rd_n", adc.rx_rd_n, 1);
        check("rst_data", rx_data, 0);
        check("rst_valid", rx_data_valid, 0);
        check("rst_first", rx_first_data, 0);
        check("rst_cnt", rx_ch_count, 0);
        check("rst_done", done, 0);
        check("rst_err", busy_err, 0);
        check("rst_active", seq_active, 0);
        check("db_t", adc.rx_db_t, 1);
        check("wr_n", adc.rx_wr_n, 1);
        check("db_o", adc.rx_db_o, 0);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        run(16, 16, 0);
        run(17, 17, 0);
        run(25, 17, 0);
        run(0, 0, 0);
        clr();
        busy_stuck = 1'b1;
        repeat (3) @(negedge sys_clk);
        num_ch = 5'd4;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        cyc = 0;
        got = 0;
        for (int i = 0; i < 1200 && !got; i++) begin
            @(negedge sys_clk);
            cyc++;
            if (busy_err) got = 1;
        end
        check("err_seen", got, 1);
        check("err_latency", 32'((cyc - 2) >= 1024 && (cyc - 2) <= 1025), 1);
        @(negedge sys_clk);
        busy_stuck = 1'b0;
        check("err_one_cycle", busy_err, 0);
        repeat (5) @(negedge sys_clk);
        check("to_done_pulses", n_done, 1);
        check("to_cs_activity", cs_lo, 0);
        check("to_rd_pulses", rd_falls, 0);
        check("to_conversions", n_cnvst, 1);
        check("to_idle", seq_active, 0);
        run(16, 16, 1);
        run(5, 5, 0);
        clr();
        num_ch = 5'd16;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        for (int i = 0; i < 600 && rd_falls < 5; i++) @(negedge sys_clk);
        check("word5_reached", rd_falls, 5);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("mr_cs_n", adc.rx_cs_n, 1);
        check("mr_rd_n", adc.rx_rd_n, 1);
        check("mr_cnt", rx_ch_count, 0);
        check("mr_done", done, 0);
        check("mr_valid", rx_data_valid, 0);
        check("mr_active", seq_active, 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        exp_q.delete();
        repeat (4) @(negedge sys_clk);
        check("mr_no_done", n_done, 0);
        check("mr_valid_count", n_valid, 4);
        run(16, 16, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
